// File: rtl/spi_master_gen_if.sv
// Word handshake between spi_master_gen and its receiver/transmitter clients.
// The master modport is the SPI master's view; slave is the client side.
interface spi_master_gen_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] rx_data;
    logic             rx_strobe;
    logic             rx_accept;
    logic             tx_request;
    logic [WIDTH-1:0] tx_data;
    logic             tx_strobe;
    logic             busy;

    modport master (
        input  rx_data, rx_strobe, tx_request,
        output rx_accept, tx_data, tx_strobe, busy
    );

    modport slave (
        output rx_data, rx_strobe, tx_request,
        input  rx_accept, tx_data, tx_strobe, busy
    );
endinterface

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: one full-duplex WIDTH-bit transfer per rx_strobe/tx_request,
// SCK generated from a clk divider, all outputs registered.
module spi_master_gen #(
    parameter int WIDTH     = 16,
    parameter int DIV       = 1,
    parameter int GAP       = 2,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    spi_master_gen_if.master bus,
    output logic            ss,
    output logic            sck,
    output logic            mosi,
    input  logic            miso
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(2 * WIDTH + 2 * GAP);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_WAIT} state_t;

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [CW-1:0]    hp_cnt;
    logic [IW-1:0]    bit_cnt;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] tx_sh, rx_sh, rx_next, load_word;
    logic             tick, sample_edge;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    // Vacated positions fill with 1 so MOSI idles high once the word is out.
    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? {1'b1, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b1};
    endfunction

    assign tick = (div_cnt == DW'(DIV - 1));

    // Even half-period index ends on a leading edge, odd on a trailing edge.
    always_comb begin
        load_word   = bus.rx_strobe ? bus.rx_data : '1;
        sample_edge = (hp_cnt[0] == CPHA);
        bit_idx     = LSB_FIRST ? bit_cnt : IW'(WIDTH - 1) - bit_cnt;
        rx_next     = rx_sh;
        if (state == S_SHIFT && tick && sample_edge)
            rx_next[bit_idx] = miso;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            ss            <= 1'b1;
            sck           <= CPOL;
            mosi          <= 1'b1;
            bus.rx_accept <= 1'b0;
            bus.tx_strobe <= 1'b0;
            bus.busy      <= 1'b0;
            bus.tx_data   <= '0;
            div_cnt       <= '0;
            hp_cnt        <= '0;
            bit_cnt       <= '0;
            tx_sh         <= '1;
            rx_sh         <= '0;
        end else begin
            bus.rx_accept <= 1'b0;
            // Divider restarts in IDLE so SETUP always lasts exactly DIV clk.
            div_cnt <= (state == S_IDLE || tick) ? '0 : div_cnt + 1'b1;
            case (state)
                S_IDLE: if (bus.rx_strobe || bus.tx_request) begin
                    state         <= S_SETUP;
                    bus.busy      <= 1'b1;
                    ss            <= 1'b0;
                    hp_cnt        <= '0;
                    bit_cnt       <= '0;
                    bus.rx_accept <= bus.rx_strobe;
                    if (!CPHA) begin
                        mosi  <= out_bit(load_word);
                        tx_sh <= shifted(load_word);
                    end else begin
                        tx_sh <= load_word;
                    end
                end
                S_SETUP: if (tick) state <= S_SHIFT;
                S_SHIFT: if (tick) begin
                    sck    <= ~sck;
                    hp_cnt <= hp_cnt + 1'b1;
                    if (sample_edge) begin
                        rx_sh   <= rx_next;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        mosi  <= out_bit(tx_sh);
                        tx_sh <= shifted(tx_sh);
                    end
                    if (hp_cnt == CW'(2 * WIDTH - 1)) begin
                        state         <= S_HOLD;
                        bus.tx_data   <= rx_next;
                        bus.tx_strobe <= bus.tx_request;
                    end
                end
                S_HOLD: if (tick) begin
                    state  <= S_GAP;
                    ss     <= 1'b1;
                    mosi   <= 1'b1;
                    hp_cnt <= '0;
                end
                S_GAP: if (tick) begin
                    hp_cnt <= hp_cnt + 1'b1;
                    if (hp_cnt == CW'(2 * GAP - 1)) state <= S_WAIT;
                end
                S_WAIT: if (!(bus.tx_strobe && bus.tx_request)) begin
                    bus.tx_strobe <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_gen.sv
// Randomised bench for spi_master_gen: a default-mode instance and an 8-bit/DIV3/mode-3/MSB-first
// instance, each talking to a behavioural SPI slave that records MOSI and drives MISO.
module tb_spi_master_gen;
    localparam int GAPC = 2;

    function automatic int p_w(input int g);   return (g == 0) ? 16 : 8; endfunction
    function automatic int p_div(input int g); return (g == 0) ? 1 : 3;  endfunction
    function automatic bit p_cpol(input int g); return (g != 0); endfunction
    function automatic bit p_cpha(input int g); return (g != 0); endfunction
    function automatic bit p_lsb(input int g);  return (g == 0); endfunction

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] rxd[2], txd[2], sw[2], cap[2];
    logic        rxs[2], txr[2], acc[2], txs[2], bsy[2];
    logic        ss[2], sck[2], mosi[2], miso[2], miso_drv[2], loop[2];
    logic        ss_prev[2], sck_prev[2];
    bit          hi_seen[2];
    int          ss_cur[2], ss_len[2], ss_rises[2], falls[2], ss_hi_run[2], ss_hi_min[2];
    int          rises[2], act_cyc[2], accs[2], ncap[2], bitpos[2];

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int W = p_w(g);
        spi_master_gen_if #(.WIDTH(W)) bus ();
        assign bus.rx_data    = rxd[g][W-1:0];
        assign bus.rx_strobe  = rxs[g];
        assign bus.tx_request = txr[g];
        assign txd[g]         = 16'(bus.tx_data);
        assign acc[g]         = bus.rx_accept;
        assign txs[g]         = bus.tx_strobe;
        assign bsy[g]         = bus.busy;
        assign miso[g]        = loop[g] ? mosi[g] : miso_drv[g];
        spi_master_gen #(
            .WIDTH(W), .DIV(p_div(g)), .GAP(GAPC),
            .CPOL(p_cpol(g)), .CPHA(p_cpha(g)), .LSB_FIRST(p_lsb(g))
        ) dut (
            .clk(clk), .reset(reset), .bus(bus),
            .ss(ss[g]), .sck(sck[g]), .mosi(mosi[g]), .miso(miso[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Slave presents its next bit (in the instance's bit order) on MISO.
    task automatic slv_drive(input int g);
        logic [15:0] t;
        if (bitpos[g] < p_w(g)) begin
            t = sw[g] >> (p_lsb(g) ? bitpos[g] : p_w(g) - 1 - bitpos[g]);
            miso_drv[g] = t[0];
        end
        bitpos[g]++;
    endtask

    // Behavioural slave + bus monitor, sampled on the falling clk edge.
    initial begin
        for (int g = 0; g < 2; g++) begin
            ss_prev[g] = 1'b1; sck_prev[g] = p_cpol(g); hi_seen[g] = 1'b0; miso_drv[g] = 1'b1;
            ss_cur[g] = 0; ss_len[g] = 0; ss_rises[g] = 0; falls[g] = 0; ss_hi_run[g] = 0;
            ss_hi_min[g] = 1000000; rises[g] = 0; act_cyc[g] = 0; accs[g] = 0; ncap[g] = 0;
            bitpos[g] = 0; cap[g] = '1;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (ss_prev[g] && !ss[g]) begin
                    falls[g]++;
                    if (hi_seen[g] && ss_hi_run[g] < ss_hi_min[g]) ss_hi_min[g] = ss_hi_run[g];
                    ss_cur[g] = 0; act_cyc[g] = 0; rises[g] = 0; ncap[g] = 0; cap[g] = '1; bitpos[g] = 0;
                    if (!p_cpha(g)) slv_drive(g);
                end
                if (!ss_prev[g] && ss[g]) begin
                    ss_rises[g]++; ss_len[g] = ss_cur[g]; ss_hi_run[g] = 0; hi_seen[g] = 1'b1;
                end
                if (!ss[g]) begin
                    ss_cur[g]++;
                    if (sck[g] != p_cpol(g)) act_cyc[g]++;
                    if (sck[g] != sck_prev[g]) begin
                        if (sck[g]) rises[g]++;
                        // Sample on leading edge for CPHA=0, trailing for CPHA=1.
                        if ((sck_prev[g] == p_cpol(g)) != p_cpha(g)) begin
                            automatic int idx = p_lsb(g) ? ncap[g] : p_w(g) - 1 - ncap[g];
                            cap[g] = (cap[g] & ~(16'h1 << idx)) | (16'(mosi[g]) << idx);
                            ncap[g]++;
                        end else begin
                            slv_drive(g);
                        end
                    end
                end else begin
                    ss_hi_run[g]++;
                end
                if (acc[g]) accs[g]++;
                ss_prev[g] = ss[g];
                sck_prev[g] = sck[g];
            end
        end
    end

    task automatic wait_idle(input int g);
        for (int i = 0; i < 1000 && bsy[g]; i++) @(negedge clk);
        chk("idle_timeout", 32'(bsy[g]), 32'd0);
    endtask

    // One transfer plus its reference expectations derived from the transfer rules.
    task automatic xfer(input int g, input bit rx_en, input bit tx_en,
                        input logic [15:0] rw, input logic [15:0] slw, input bit lp);
        int w, d, a0, r0;
        logic [15:0] mask, em;
        w = p_w(g); d = p_div(g);
        mask = 16'((32'h1 << w) - 1);
        em = (rx_en ? rw : 16'hFFFF) & mask;
        wait_idle(g);
        sw[g] = slw; loop[g] = lp; rxd[g] = rw; rxs[g] = rx_en; txr[g] = tx_en;
        a0 = accs[g]; r0 = ss_rises[g];
        @(negedge clk);
        rxs[g] = 1'b0;
        for (int n = 0; n < 2000 && ss_rises[g] == r0; n++) @(negedge clk);
        chk("xfer_done", 32'(ss_rises[g] - r0), 32'd1);
        repeat (2 * GAPC * d + 2) @(negedge clk);
        chk("ss_low_len", 32'(ss_len[g]), 32'(d * (2 * w + 2)));
        chk("sck_rises", 32'(rises[g]), 32'(w));
        chk("sck_active", 32'(act_cyc[g]), 32'(w * d));
        chk("rx_accepts", 32'(accs[g] - a0), 32'(rx_en));
        chk("mosi_word", 32'(cap[g] & mask), 32'(em));
        chk("tx_data", 32'(txd[g]), 32'(lp ? em : (slw & mask)));
        chk("tx_strobe", 32'(txs[g]), 32'(tx_en));
        chk("busy_wait", 32'(bsy[g]), 32'(tx_en));
        if (tx_en) begin
            txr[g] = 1'b0;
            @(negedge clk);
            chk("tx_strobe_clr", 32'(txs[g]), 32'd0);
            chk("busy_clr", 32'(bsy[g]), 32'd0);
        end
    endtask

    initial begin
        int a0, f0;
        logic [1:0] mode;
        for (int g = 0; g < 2; g++) begin
            rxd[g] = '0; rxs[g] = 1'b0; txr[g] = 1'b0; sw[g] = '0; loop[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_ss", 32'(ss[g]), 32'd1);
            chk("rst_sck", 32'(sck[g]), 32'(p_cpol(g)));
            chk("rst_mosi", 32'(mosi[g]), 32'd1);
            chk("rst_accept", 32'(acc[g]), 32'd0);
            chk("rst_tx_strobe", 32'(txs[g]), 32'd0);
            chk("rst_busy", 32'(bsy[g]), 32'd0);
            chk("rst_tx_data", 32'(txd[g]), 32'd0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        xfer(0, 1'b1, 1'b0, 16'hA55A, 16'h0000, 1'b1);
        xfer(0, 1'b0, 1'b1, 16'h0000, 16'h1234, 1'b0);
        xfer(0, 1'b1, 1'b1, 16'h00FF, 16'h8001, 1'b0);
        xfer(1, 1'b1, 1'b0, 16'h00C3, 16'h005A, 1'b0);
        xfer(1, 1'b0, 1'b1, 16'h0000, 16'h00A6, 1'b0);
        for (int i = 0; i < 8; i++) begin
            mode = 2'($urandom_range(1, 3));
            xfer($urandom_range(0, 1), mode[0], mode[1], 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)));
        end

        // rx_strobe held high: back-to-back transfers, one accept each.
        wait_idle(0);
        a0 = accs[0]; f0 = falls[0];
        rxd[0] = 16'($urandom); rxs[0] = 1'b1;
        repeat (200) @(negedge clk);
        rxs[0] = 1'b0;
        wait_idle(0);
        chk("held_accepts", 32'(accs[0] - a0), 32'(falls[0] - f0));
        chk("held_xfers", 32'(falls[0] - f0 >= 4), 32'd1);
        chk("ss_gap_min", 32'(ss_hi_min[0] >= 2 * GAPC * p_div(0)), 32'd1);

        // Reset in the middle of a transfer.
        rxd[0] = 16'h0F0F; rxs[0] = 1'b1; txr[0] = 1'b1;
        @(negedge clk);
        rxs[0] = 1'b0;
        for (int n = 0; n < 500 && rises[0] < 7; n++) @(negedge clk);
        chk("rst_mid_reached", 32'(rises[0] >= 7), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_ss", 32'(ss[0]), 32'd1);
        chk("abort_sck", 32'(sck[0]), 32'd0);
        chk("abort_mosi", 32'(mosi[0]), 32'd1);
        chk("abort_tx_strobe", 32'(txs[0]), 32'd0);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        txr[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_strobe", 32'(txs[0]), 32'd0);
        xfer(0, 1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
- Parametrised successor to the fixed 16-bit mode-0 SPI master; moves WIDTH-bit words between the line receiver/transmitter and the CPU over SPI.
- Fully synchronous to clk; SCK comes from an internal divider, not a derived clock.
- Adds configurable width, SCK rate, CPOL/CPHA, bit order, inter-transfer gap and a busy flag.
- The rx/tx handshake semantics of the current block are kept, except that rx_accept becomes a single-clk pulse.

Parameters:
- WIDTH, 16: bits per transfer (≥2).
- DIV, 1: SCK half-period in clk cycles (≥1).
- GAP, 2: minimum SS-deasserted time, in SCK periods (≥1).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- LSB_FIRST, 1: 1 = bit 0 shifted first; 0 = MSB first.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- rx_data  in  WIDTH  word from receiver, sent on MOSI.
- rx_strobe  in  1  receiver has a word.
- rx_accept  out  1  one-clk pulse: rx_data latched.
- tx_request  in  1  transmitter wants a word from CPU.
- tx_data  out  WIDTH  word received on MISO.
- tx_strobe  out  1  tx_data valid; held until tx_request low.
- busy  out  1  state != IDLE.
- ss  out  1  slave select, active-low.
- sck  out  1  SPI clock.
- mosi  out  1  master out.
- miso  in  1  master in.

Behaviour:
- Reset values:
  - ss=1, sck=CPOL, mosi=1, rx_accept=0, tx_strobe=0, busy=0, tx_data=0.
  - state=IDLE, all counters 0.
  - A reset mid-transfer aborts it immediately; no partial tx_strobe.
- Half-period tick: a counter wraps every DIV clk cycles; all SPI events occur on ticks.
- State IDLE (ss=1, sck=CPOL, mosi=1):
  - On rx_strobe | tx_request, go to SETUP on the next clk.
  - If rx_strobe: shift reg <= rx_data; rx_accept=1 for exactly that clk.
  - Else: shift reg <= all ones; rx_accept stays 0.
  - rx_strobe has priority. When both are high, one full-duplex transfer serves both.
- State SETUP (DIV clk): ss=0, sck=CPOL.
  - CPHA=0: mosi = first bit.
  - CPHA=1: mosi is driven on the first edge.
- State SHIFT (2*WIDTH half-periods): sck toggles at each half-period boundary.
  - Sample edge (leading if CPHA=0, trailing if CPHA=1): capture miso into the receive shift reg at the next bit position.
  - Drive edge (the other edge): present the next bit on mosi.
  - Bit order is set by LSB_FIRST. Vacated transmit bits fill with 1.
  - Bit counter counts samples 0..WIDTH-1; the last sample ends SHIFT.
- State HOLD (DIV clk): sck=CPOL, ss=0, then ss=1.
  - tx_data <= receive reg, loaded on the clk HOLD is entered.
  - If tx_request is high at that moment, tx_strobe<=1.
- State GAP (GAP*2*DIV clk): ss=1, sck=CPOL, mosi=1. Then go to WAIT.
- State WAIT:
  - If tx_strobe & tx_request, stay.
  - Otherwise clear tx_strobe and go to IDLE.
  - A new transfer therefore needs tx_request low and tx_strobe low first.
- Transfer length:
  - ss low for DIV*(2*WIDTH+2) clk.
  - Back-to-back period ≥ DIV*(2*WIDTH+2+2*GAP)+2 clk.
- rx_strobe held high after rx_accept starts a further transfer once IDLE is reached. The receiver must drop it within the transfer.
- tx_data holds its value until the next HOLD.

Test Plan:
- Defaults, miso=mosi loopback, rx_strobe with rx_data=0xA55A -> rx_accept one clk; ss low 34 clk; 16 sck rising edges; mosi LSB-first 0,1,0,1,1,0,1,0...; tx_data=0xA55A; tx_strobe=0.
- tx_request only, slave drives 0x1234 LSB-first on miso -> mosi constant 1; tx_data=0x1234; tx_strobe=1 until tx_request drops, clears 1 clk later; busy=0 the following clk.
- rx_strobe and tx_request together, rx_data=0x00FF, miso=0x8001 -> a single transfer; rx_accept pulses; tx_data=0x8001; tx_strobe=1.
- rx_strobe held high continuously (defaults) -> consecutive transfers; ss high ≥4 clk between them; exactly one rx_accept per transfer.
- WIDTH=8, DIV=3, CPOL=1, CPHA=1, LSB_FIRST=0, rx_data=0xC3 -> sck idle 1, half-period 3 clk; mosi 1,1,0,0,0,0,1,1 changes on falling edges; miso sampled on rising edges; ss low 54 clk.
- reset asserted at bit 7 of a transfer -> ss=1, sck=CPOL, mosi=1 in the same cycle; no tx_strobe; the next rx_strobe gives a clean full transfer.
